// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked 8-function ALU with NZCV flags and start/done handshake.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for func=111.
module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   func,
    output logic [N-1:0] Y,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        F_ADD = 3'b000,
        F_SUB = 3'b001,
        F_AND = 3'b010,
        F_OR  = 3'b011,
        F_XOR = 3'b100,
        F_LSL = 3'b101,
        F_LSR = 3'b110,
        F_MUL = 3'b111
    } func_t;

    state_t        state, state_nxt;
    logic [N-1:0]  a_q, b_q;
    func_t         func_q;

    logic [N-1:0]  alu_y;
    logic          alu_c, alu_v;
    logic [N:0]    wide;
    logic [SW-1:0] shamt;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SW:0] CNT_LAST = (SW+1)'(N - 1);

    logic [N-1:0] acc, mcand, mplier, mul_sum;
    logic [SW:0]  cnt;
    logic         mul_last;

    assign mul_sum  = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CNT_LAST);
`endif

    // Single-cycle datapath; func=111 falls to default (Y=0) when no multiplier is built
    always_comb begin
        wide  = '0;
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        shamt = b_q[SW-1:0];
        case (func_q)
            F_ADD: begin
                wide  = {1'b0, a_q} + {1'b0, b_q};
                alu_y = wide[N-1:0];
                alu_c = wide[N];
                alu_v = (a_q[N-1] == b_q[N-1]) && (alu_y[N-1] != a_q[N-1]);
            end
            F_SUB: begin
                wide  = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
                alu_y = wide[N-1:0];
                alu_c = wide[N];
                alu_v = (a_q[N-1] != b_q[N-1]) && (alu_y[N-1] != a_q[N-1]);
            end
            F_AND: alu_y = a_q & b_q;
            F_OR:  alu_y = a_q | b_q;
            F_XOR: alu_y = a_q ^ b_q;
            // Extra bit beside the operand catches the last bit shifted out
            F_LSL: begin
                wide  = {1'b0, a_q} << shamt;
                alu_y = wide[N-1:0];
                alu_c = wide[N];
            end
            F_LSR: begin
                wide  = {a_q, 1'b0} >> shamt;
                alu_y = wide[N:1];
                alu_c = wide[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    state_nxt = (func == F_MUL) ? S_MUL : S_EXEC;
`else
                    state_nxt = S_EXEC;
`endif
                end
            end
            S_EXEC: state_nxt = S_FIN;
            S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_last) state_nxt = S_FIN;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            func_q <= F_ADD;
            Y      <= '0;
            flags  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        func_q <= func_t'(func);
                        busy   <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                        acc    <= '0;
                        mcand  <= A;
                        mplier <= B;
                        cnt    <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    Y     <= alu_y;
                    flags <= {alu_y[N-1], (alu_y == '0), alu_c, alu_v};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        Y     <= mul_sum;
                        flags <= {mul_sum[N-1], (mul_sum == '0), 2'b00};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (N=32) against an arithmetic reference model.
// Expectations for func=111 follow whether ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A, B;
    logic [2:0]   func;
    logic [N-1:0] Y;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .func  (func),
        .Y     (Y),
        .flags (flags),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true signed/unsigned results, overflow = result not representable in N bits
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  output logic [31:0] y, output logic [3:0] fl, output int lat);
        logic [63:0]        w;
        longint             sa, sb, sr;
        logic signed [31:0] ys;
        int                 s;
        logic               c, v;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        s   = int'(b % 32);
        sa  = $signed(a);
        sb  = $signed(b);
        sr  = 0;
        y   = '0;
        case (f)
            3'd0: begin
                w  = 64'(a) + 64'(b);
                y  = w[31:0];
                c  = w[32];
                sr = sa + sb;
                ys = y;
                v  = (sr != ys);
            end
            3'd1: begin
                y  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                ys = y;
                v  = (sr != ys);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin
                y = a << s;
                c = (s == 0) ? 1'b0 : a[32-s];
            end
            3'd6: begin
                y = a >> s;
                c = (s == 0) ? 1'b0 : a[s-1];
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                w   = 64'(a) * 64'(b);
                y   = w[31:0];
                lat = N;
`else
                y   = '0;
`endif
            end
        endcase
        fl = {y[31], (y == 0), c, v};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [31:0] ey;
        logic [3:0]  ef;
        int          lat, edges, busy_bad;
        bit          seen;
        model(a, b, f, ey, ef, lat);
        @(negedge clk);
        A = a; B = b; func = f; start = 1'b1;
        @(posedge clk);
        #1 check("busy_after_start", busy, 1'b1);
        edges = 0; seen = 0; busy_bad = 0;
        // Operands, func and stray start pulses change while busy; none may affect the result
        while (!seen && edges < 200) begin
            @(negedge clk);
            start = 1'($urandom);
            A = $urandom; B = $urandom; func = 3'($urandom);
            @(posedge clk);
            edges++;
            #1;
            if (done) seen = 1;
            else if (!busy) busy_bad++;
        end
        check("latency", edges, lat);
        check("Y", Y, ey);
        check("flags", flags, ef);
        check("busy_in_flight", busy_bad, 0);
        check("busy_at_done", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 check("done_pulse_width", done, 1'b0);
        check("Y_hold", Y, ey);
        check("flags_hold", flags, ef);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ey;
        logic [3:0]  ef;
        int          lat;
        int          dn;
        bit          seen;

        rst = 1'b0; start = 1'b0; A = '0; B = '0; func = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_Y", Y, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_Y", Y, 0);
        check("idle_flags", flags, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        run_op(32'h7FFF_FFFF, 32'h1, 3'b000);
        run_op(32'hFFFF_FFFF, 32'h1, 3'b000);
        run_op(32'd5, 32'd5, 3'b001);
        run_op(32'd3, 32'd5, 3'b001);
        run_op(32'h8000_0001, 32'h1, 3'b101);
        run_op(32'h8000_0001, 32'h21, 3'b110);
        run_op(32'h1234_5678, 32'h0, 3'b101);
        run_op(32'h1234_5678, 32'h20, 3'b110);
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b010);
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b011);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
        run_op(32'd12345, 32'd678, 3'b111);
        run_op(32'd7, 32'd9, 3'b111);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = '0;
                1: rb = '1;
                default: ;
            endcase
            run_op(ra, rb, 3'($urandom_range(0, 7)));
        end

        // start held high across done: second op accepted only after the done cycle
        @(negedge clk);
        A = 32'd3; B = 32'd4; func = 3'b000; start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1 check($sformatf("held_start_done_e%0d", e), done, (e == 1 || e == 4));
        end
        check("held_start_Y", Y, 32'd7);
        @(negedge clk) start = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-operation aborts with no done pulse
        @(negedge clk);
        A = 32'd12345; B = 32'd678; func = 3'b111; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        model(32'd12345, 32'd678, 3'b111, ey, ef, lat);
        repeat ((lat > 1) ? 9 : 0) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_Y", Y, 0);
        check("abort_flags", flags, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        dn = 0;
        repeat (50) begin
            @(posedge clk);
            #1 if (done) seen = 1;
            if (busy) dn++;
        end
        check("abort_no_done", seen, 0);
        check("abort_no_busy", dn, 0);
        check("abort_Y_after", Y, 0);

        run_op(32'd100, 32'd23, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
